ramb_asym_dp: RTL



---
 rtl/ramb_asym_dp_if.sv | 41 ++++
 rtl/ramb_asym_dp.sv | 135 +++++++++++++
 2 files changed

// File: rtl/ramb_asym_dp_if.sv
// Port bundle for ramb_asym_dp: two independent access ports plus the collision flag.
// The master drives the requests and the slave (the RAM) drives the read data.
interface ramb_asym_dp_if #(
    parameter int MEM_BITS = 16384,
    parameter int WIDTH_A  = 2,
    parameter int WIDTH_B  = 32
);
    localparam int AW_A  = $clog2(MEM_BITS / WIDTH_A);
    localparam int AW_B  = $clog2(MEM_BITS / WIDTH_B);
    // A port as wide as the whole array still carries a one-bit (ignored) address
    localparam int AWA_P = (AW_A > 0) ? AW_A : 1;
    localparam int AWB_P = (AW_B > 0) ? AW_B : 1;

    logic               ENA;
    logic               WEA;
    logic               SSRA;
    logic [AWA_P-1:0]   ADDRA;
    logic [WIDTH_A-1:0] DIA;
    logic [WIDTH_A-1:0] DOA;

    logic               ENB;
    logic               WEB;
    logic               SSRB;
    logic [AWB_P-1:0]   ADDRB;
    logic [WIDTH_B-1:0] DIB;
    logic [WIDTH_B-1:0] DOB;

    logic               COLLISION;

    modport master (
        output ENA, WEA, SSRA, ADDRA, DIA,
        output ENB, WEB, SSRB, ADDRB, DIB,
        input  DOA, DOB, COLLISION
    );

    modport slave (
        input  ENA, WEA, SSRA, ADDRA, DIA,
        input  ENB, WEB, SSRB, ADDRB, DIB,
        output DOA, DOB, COLLISION
    );
endinterface

// File: rtl/ramb_asym_dp.sv
// Single-clock true dual-port RAM with asymmetric power-of-two port widths over one bit array.
// Define RAMB_ASYM_DO_REG_EN to add an extra output register on each port.
module ramb_asym_dp #(
    parameter int                 MEM_BITS     = 16384,
    parameter int                 WIDTH_A      = 2,
    parameter int                 WIDTH_B      = 32,
    parameter string              WRITE_MODE_A = "WRITE_FIRST",
    parameter string              WRITE_MODE_B = "WRITE_FIRST",
    parameter logic [WIDTH_A-1:0] INIT_A       = '0,
    parameter logic [WIDTH_B-1:0] INIT_B       = '0,
    parameter logic [WIDTH_A-1:0] SRVAL_A      = '0,
    parameter logic [WIDTH_B-1:0] SRVAL_B      = '0
) (
    input  logic          CLK,
    input  logic          RST_N,
    ramb_asym_dp_if.slave bus
);
    localparam int LOGM = $clog2(MEM_BITS);
    localparam int LA   = $clog2(WIDTH_A);
    localparam int LB   = $clog2(WIDTH_B);
    localparam int AW_A = LOGM - LA;
    localparam int AW_B = LOGM - LB;
    localparam int PW   = LOGM + 1;

    localparam bit A_WF = (WRITE_MODE_A == "WRITE_FIRST");
    localparam bit A_RF = (WRITE_MODE_A == "READ_FIRST");
    localparam bit B_WF = (WRITE_MODE_B == "WRITE_FIRST");
    localparam bit B_RF = (WRITE_MODE_B == "READ_FIRST");

`ifdef RAMB_ASYM_DO_REG_EN
    localparam bit OUT_REG = 1'b1;
`else
    localparam bit OUT_REG = 1'b0;
`endif

    logic [MEM_BITS-1:0] r_mem;
    logic [WIDTH_A-1:0]  r_doa_p0;
    logic [WIDTH_B-1:0]  r_dob_p0;
    logic                r_collision;

    logic [PW-1:0]       w_a_lo;
    logic [PW-1:0]       w_b_lo;
    logic [WIDTH_A-1:0]  w_a_old;
    logic [WIDTH_B-1:0]  w_b_old;
    logic [WIDTH_A-1:0]  w_doa_nxt;
    logic [WIDTH_B-1:0]  w_dob_nxt;
    logic                w_overlap;
    logic                w_collision;

    // Word address -> starting bit of the word in the little-endian packed array
    assign w_a_lo  = (AW_A > 0) ? (PW'(bus.ADDRA) << LA) : '0;
    assign w_b_lo  = (AW_B > 0) ? (PW'(bus.ADDRB) << LB) : '0;

    assign w_a_old = r_mem[w_a_lo +: WIDTH_A];
    assign w_b_old = r_mem[w_b_lo +: WIDTH_B];

    assign w_overlap   = (w_a_lo < (w_b_lo + PW'(WIDTH_B))) &&
                         (w_b_lo < (w_a_lo + PW'(WIDTH_A)));
    assign w_collision = bus.ENA && bus.ENB && w_overlap && (bus.WEA || bus.WEB);

    // Array: B is written last so it wins any overlapping bits; writes during reset are dropped
    always_ff @(posedge CLK) begin
        if (RST_N) begin
            if (bus.ENA && bus.WEA)
                r_mem[w_a_lo +: WIDTH_A] <= bus.DIA;
            if (bus.ENB && bus.WEB)
                r_mem[w_b_lo +: WIDTH_B] <= bus.DIB;
        end
    end

    // With the output register present, SSR is applied there instead of in this stage
    always_comb begin
        w_doa_nxt = r_doa_p0;
        if (bus.ENA) begin
            if (bus.SSRA && !OUT_REG)
                w_doa_nxt = SRVAL_A;
            else if (!bus.WEA)
                w_doa_nxt = w_a_old;
            else if (A_WF)
                w_doa_nxt = bus.DIA;
            else if (A_RF)
                w_doa_nxt = w_a_old;
        end
    end

    always_comb begin
        w_dob_nxt = r_dob_p0;
        if (bus.ENB) begin
            if (bus.SSRB && !OUT_REG)
                w_dob_nxt = SRVAL_B;
            else if (!bus.WEB)
                w_dob_nxt = w_b_old;
            else if (B_WF)
                w_dob_nxt = bus.DIB;
            else if (B_RF)
                w_dob_nxt = w_b_old;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_doa_p0    <= INIT_A;
            r_dob_p0    <= INIT_B;
            r_collision <= 1'b0;
        end else begin
            r_doa_p0    <= w_doa_nxt;
            r_dob_p0    <= w_dob_nxt;
            r_collision <= w_collision;
        end
    end

`ifdef RAMB_ASYM_DO_REG_EN
    logic [WIDTH_A-1:0] r_doa_p1;
    logic [WIDTH_B-1:0] r_dob_p1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_doa_p1 <= INIT_A;
            r_dob_p1 <= INIT_B;
        end else begin
            r_doa_p1 <= (bus.ENA && bus.SSRA) ? SRVAL_A : r_doa_p0;
            r_dob_p1 <= (bus.ENB && bus.SSRB) ? SRVAL_B : r_dob_p0;
        end
    end

    assign bus.DOA = r_doa_p1;
    assign bus.DOB = r_dob_p1;
`else
    assign bus.DOA = r_doa_p0;
    assign bus.DOB = r_dob_p0;
`endif

    assign bus.COLLISION = r_collision;

endmodule
